// File: rtl/alu_operand_pkg.sv
// Shared types and constants for the ALU operand-B select pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package alu_operand_pkg;

  // Default operand width of the datapath
  localparam int DEF_WIDTH = 32;

  // Skid-buffer occupancy states
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } state_t;

  // Select codes for the standard operand-B sources
  localparam logic [2:0] SEL_REGB   = 3'd0;
  localparam logic [2:0] SEL_FOUR   = 3'd1;
  localparam logic [2:0] SEL_IMM_SE = 3'd2;
  localparam logic [2:0] SEL_IMM_SH = 3'd3;
  localparam logic [2:0] SEL_OTHER  = 3'd4;

endpackage

// File: rtl/alu_operand_pipe_operand_sel.sv
// N_IN-way operand selector; any code at or past the last entry picks the last entry.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module operand_sel #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 5,
  parameter int SEL_W = 3
) (
  input  logic [N_IN*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      dout
);

  // Start from the fallback entry, then override on an exact match below it
  always_comb begin
    dout = in_flat[(N_IN-1)*WIDTH +: WIDTH];
    for (int i = 0; i < N_IN - 1; i++) begin
      if (sel == SEL_W'(i)) begin
        dout = in_flat[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/alu_operand_pipe.sv
// Selects one operand-B source and launches it through a two-entry skid buffer.
// Latency: value accepted at edge k is on out (out_valid=1) right after edge k.
// Backpressure: in_ready drops only when both entries are full; decoded from state, no path from out_ready.
module alu_operand_pipe
  import alu_operand_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_IN  = 5,
  parameter int SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] sel_val;
  logic             sel_err_q;
  logic             accept;
  logic             pop;
  logic             sel_bad;
  logic             head_ld_new;
  logic             head_ld_skid;
  logic             skid_ld_new;

  operand_sel #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_sel (
    .in_flat (in_flat),
    .sel     (sel),
    .dout    (sel_val)
  );

  assign in_ready  = (state_q != TWO) & ~reset;
  assign out_valid = (state_q != EMPTY);
  assign out       = head_q;
  assign sel_err   = sel_err_q;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // Zero-extended compare so the check stays correct when 2**SEL_W == N_IN
  assign sel_bad   = (32'(sel) >= 32'(N_IN));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and register load strobes from accept/pop in the current state
  always_comb begin
    state_d      = state_q;
    head_ld_new  = 1'b0;
    head_ld_skid = 1'b0;
    skid_ld_new  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          head_ld_new = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          head_ld_new = 1'b1;
        end else if (accept) begin
          state_d     = TWO;
          skid_ld_new = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d      = ONE;
          head_ld_skid = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Head/skid data registers and the sticky select-error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      skid_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      if (head_ld_new) begin
        head_q <= sel_val;
      end else if (head_ld_skid) begin
        head_q <= skid_q;
      end
      if (skid_ld_new) begin
        skid_q <= sel_val;
      end
      if (accept && sel_bad) begin
        sel_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_pipe.sv
// Randomised and directed bench for alu_operand_pipe against a queue-based model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_alu_operand_pipe;

  localparam int W  = 32;
  localparam int NI = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NI*W-1:0] in_flat = '0;
  logic [2:0]      sel = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    out;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            sel_err;

  logic [15:0] s_in_flat = '0;
  logic [0:0]  s_sel = '0;
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [7:0]  s_out;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic        s_sel_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] mq[$];
  bit           m_err = 1'b0;

  always #5 clk = ~clk;

  alu_operand_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_flat   (in_flat),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  alu_operand_pipe #(.WIDTH(8), .N_IN(2), .SEL_W(1)) dut_s (
    .clk       (clk),
    .reset     (reset),
    .in_flat   (s_in_flat),
    .sel       (s_sel),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .out       (s_out),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .sel_err   (s_sel_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference selection: codes at or beyond the last entry take the last entry
  function automatic logic [W-1:0] ref_sel(input logic [NI*W-1:0] f, input logic [2:0] s);
    int idx;
    idx = (int'(s) >= NI - 1) ? NI - 1 : int'(s);
    return f[idx*W +: W];
  endfunction

  // Model: a FIFO of depth 2; reset empties it
  always @(posedge clk) begin
    bit acc;
    bit pp;
    if (reset) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      acc = in_valid && (mq.size() < 2);
      pp  = out_ready && (mq.size() > 0);
      if (pp) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(ref_sel(in_flat, sel));
        if (int'(sel) >= NI) m_err = 1'b1;
      end
    end
  end

  // Compare DUT against model on every falling edge
  always @(negedge clk) begin
    check("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("m_in_ready", 32'(in_ready), 32'((mq.size() < 2) && !reset));
    check("m_sel_err", 32'(sel_err), 32'(m_err));
    if (mq.size() != 0) check("m_out", out, mq[0]);
  end

  logic [W-1:0] sweep_exp [8];
  logic [W-1:0] va;
  logic [W-1:0] vexp;

  initial begin
    sweep_exp[0] = 32'h1000_0000; sweep_exp[1] = 32'h1000_0001;
    sweep_exp[2] = 32'h1000_0002; sweep_exp[3] = 32'h1000_0003;
    sweep_exp[4] = 32'h1000_0004; sweep_exp[5] = 32'h1000_0004;
    sweep_exp[6] = 32'h1000_0004; sweep_exp[7] = 32'h1000_0004;

    // Reset with in_valid held high
    in_valid = 1'b1;
    for (int i = 0; i < NI; i++) in_flat[i*W +: W] = 32'h1000_0000 + 32'(i);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out", out, 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_sel_err", 32'(sel_err), 32'd0);
    end
    reset = 1'b0;
    sel = 3'd0;
    out_ready = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Select sweep 0..7, one accept per cycle
    for (int s = 0; s < 8; s++) begin
      @(posedge clk); #1;
      check("sweep_out", out, sweep_exp[s]);
      check("sweep_valid", 32'(out_valid), 32'd1);
      check("sweep_err", 32'(sel_err), (s >= 5) ? 32'd1 : 32'd0);
      if (s < 7) sel = 3'(s + 1);
      else in_valid = 1'b0;
    end
    @(posedge clk); #1;

    // Backpressure: fill both entries, then drain
    out_ready = 1'b0;
    sel = 3'd0;
    in_flat[0 +: W] = 32'hAAAA_0001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp_out_a", out, 32'hAAAA_0001);
    check("bp_ready_one", 32'(in_ready), 32'd1);
    in_flat[0 +: W] = 32'hBBBB_0002;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_ready_two", 32'(in_ready), 32'd0);
    check("bp_hold_a", out, 32'hAAAA_0001);
    repeat (2) @(posedge clk);
    #1;
    check("bp_hold_a2", out, 32'hAAAA_0001);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_out_b", out, 32'hBBBB_0002);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_empty", 32'(out_valid), 32'd0);

    // Streaming 16 values with accept and pop every cycle
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      for (int e = 0; e < NI; e++) in_flat[e*W +: W] = $urandom();
      sel = 3'($urandom_range(0, 7));
      va = ref_sel(in_flat, sel);
      @(posedge clk); #1;
      check("stream_out", out, va);
      check("stream_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset while two entries are held
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("two_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_out", out, 32'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst_no_stale", 32'(out_valid), 32'd0);
    end

    // Random traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      for (int e = 0; e < NI; e++) in_flat[e*W +: W] = $urandom();
      sel       = 3'($urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 49) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Two-input, 8-bit instance: sel=1 picks entry 1 without an error
    s_in_flat = {8'hB2, 8'hA1};
    s_sel = 1'b1;
    s_in_valid = 1'b1;
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    check("small_sel1", 32'(s_out), 32'h0000_00B2);
    check("small_err", 32'(s_sel_err), 32'd0);
    s_sel = 1'b0;
    @(posedge clk); #1;
    vexp = 32'h0000_00A1;
    check("small_sel0", 32'(s_out), vexp);
    check("small_valid", 32'(s_out_valid), 32'd1);
    s_in_valid = 1'b0;
    @(posedge clk); #1;
    check("small_err_end", 32'(s_sel_err), 32'd0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
